// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns, scan FSM states and helpers shared by the seven-segment scanner.
package seven_seg_pkg;
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111100;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1100111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam int DEFAULT_SLOT_W  = $clog2(1000);
  localparam int DEFAULT_DIGIT_W = $clog2(4);
  typedef enum logic {BLANK, SHOW} scan_state_t;
  function automatic int width_of(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_scan_decode.sv
// seven_seg_decode: combinational BCD to seven-segment pattern (non-BCD codes show a dash).
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = seg_decode(bcd);
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: tear-free time-multiplexed seven-segment driver with per-slot anti-ghost blanking.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [4*DIGITS-1:0]   bcd_i,
  input  logic                  load_i,
  input  logic                  enable_i,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);
  localparam int SW = width_of(SLOT_CYCLES);
  localparam int DW = width_of(DIGITS);
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [DW-1:0] digit, digit_nxt;
  scan_state_t state, state_nxt;
  logic [4*DIGITS-1:0] staging, shadow;
  logic pending, slot_wrap, last_digit, frame_end, blank_lz;
  logic [3:0] cur;
  logic [6:0] seg_dec;
  always_comb begin
    slot_wrap  = slot_cnt == SW'(SLOT_CYCLES - 1);
    last_digit = digit == DW'(DIGITS - 1);
    frame_end  = enable_i && slot_wrap && last_digit;
    slot_nxt   = !enable_i || slot_wrap ? '0 : slot_cnt + 1'b1;
    digit_nxt  = !enable_i || (slot_wrap && last_digit) ? '0 : slot_wrap ? digit + 1'b1 : digit;
    state_nxt  = slot_nxt >= SW'(BLANK_CYCLES) ? SHOW : BLANK;
    cur        = shadow[4*int'(digit) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank_lz   = digit != '0 && (shadow >> (4*int'(digit))) == '0;
`else
    blank_lz   = 1'b0;
`endif
  end
  seven_seg_decode u_decode (.bcd(cur), .seg(seg_dec));
  // shadow only changes at a frame boundary, so a displayed frame never mixes two loads
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      slot_cnt   <= '0;
      digit      <= '0;
      state      <= BLANK;
      segments   <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      staging    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
    end else begin
      slot_cnt   <= slot_nxt;
      digit      <= digit_nxt;
      state      <= state_nxt;
      frame_done <= frame_end;
      segments   <= enable_i && state == SHOW && !blank_lz ? seg_dec : '0;
      digit_en   <= enable_i && state == SHOW ? DIGITS'(1) << digit : '0;
      staging    <= load_i ? bcd_i : staging;
      pending    <= frame_end ? 1'b0 : load_i | pending;
      shadow     <= frame_end && load_i ? bcd_i : frame_end && pending ? staging : shadow;
    end
  end
endmodule
